im2col_window_ctrl: RTL

- Parametrised sliding-window patch generator for the img2col front end. It replaces the fixed 5x5, single-stride processing-unit controller.
- Accepts one K-pixel image column per handshake and keeps a K x K window in an internal column shift register, so overlapping columns are reused rather than re-read.
- Emits one flattened K*K patch per window position, honouring a configurable horizontal stride.
- Processes N_BANDS row-bands of IMG_W columns each. Downstream is the PE array.

---
 rtl/im2col_window_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/im2col_window_ctrl.sv
// Sliding K x K window patch generator: takes one K-pixel column per handshake and emits flattened K*K patches.
// Latency: one cycle from column accept to patch_valid; a new patch can replace a consumed one in the same cycle.
// Backpressure: single-entry output slot; col_ready drops while a patch is held and patch_ready is low.
module im2col_window_ctrl #(
    parameter int DATA_W  = 16,
    parameter int K       = 5,
    parameter int STRIDE  = 1,
    parameter int IMG_W   = 28,
    parameter int N_BANDS = 24,
    parameter int CW      = $clog2(IMG_W),
    parameter int BW      = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start,
    input  logic                    col_valid,
    output logic                    col_ready,
    input  logic [K*DATA_W-1:0]     col_in,
    output logic                    patch_valid,
    input  logic                    patch_ready,
    output logic [K*K*DATA_W-1:0]   patch_out,
    output logic [CW-1:0]           patch_col,
    output logic [BW-1:0]           patch_row,
    output logic                    busy,
    output logic                    done
);

    // Stride phase counter width; a stride of 1 still needs a one-bit register.
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [BW-1:0] BAND_LAST = BW'(N_BANDS - 1);
    localparam logic [SW-1:0] PH_LAST   = SW'(STRIDE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t             state;
    logic [CW-1:0]      col_cnt;
    logic [BW-1:0]      band_cnt;
    logic [SW-1:0]      ph;

    // Only the K-1 most recent columns are stored: the oldest window column
    // is shifted out on the same accept that brings col_in in, so it is never
    // part of a patch. win[0] is the oldest stored column.
    logic [K*DATA_W-1:0] win [K-1];

    logic               col_acc;
    logic               last_col;
    logic               last_band;
    logic               in_range;
    logic               emit;
    logic [K*K*DATA_W-1:0] next_patch;

    // Input handshake: accept a column only in RUN and when the output slot is free or being drained this cycle.
    always_comb begin
        col_ready = (state == ST_RUN) && (!patch_valid || patch_ready);
        col_acc   = col_valid && col_ready;
        last_col  = (col_cnt == COL_LAST);
        last_band = (band_cnt == BAND_LAST);
        in_range  = (col_cnt >= COL_FIRST);
        emit      = col_acc && in_range && (ph == '0);
    end

    // Assemble the patch seen after this accept: stored columns 0..K-2 plus col_in as the newest column.
    always_comb begin
        next_patch = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c == K - 1) begin
                    next_patch[(r*K + c)*DATA_W +: DATA_W] = col_in[r*DATA_W +: DATA_W];
                end else begin
                    next_patch[(r*K + c)*DATA_W +: DATA_W] = win[c][r*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Frame FSM, window shift register, counters and registered output slot.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            col_cnt     <= '0;
            band_cnt    <= '0;
            ph          <= '0;
            for (int c = 0; c < K - 1; c++) begin
                win[c] <= '0;
            end
            patch_valid <= 1'b0;
            patch_out   <= '0;
            patch_col   <= '0;
            patch_row   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            // Output slot: a new load wins over a consume in the same cycle, so there is no bubble.
            if (emit) begin
                patch_valid <= 1'b1;
                patch_out   <= next_patch;
                patch_col   <= col_cnt - COL_FIRST;
                patch_row   <= band_cnt;
            end else if (patch_ready) begin
                patch_valid <= 1'b0;
            end

            // The window is never cleared at a band boundary; the first K-1
            // columns of a band overwrite it before the first patch of that band.
            if (col_acc) begin
                for (int c = 0; c < K - 2; c++) begin
                    win[c] <= win[c + 1];
                end
                win[K - 2] <= col_in;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        col_cnt  <= '0;
                        band_cnt <= '0;
                        ph       <= '0;
                    end
                end
                ST_RUN: begin
                    if (col_acc) begin
                        // The stride phase only advances once a full window exists.
                        if (in_range) begin
                            ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
                        end
                        if (last_col) begin
                            col_cnt <= '0;
                            ph      <= '0;
                            if (last_band) begin
                                state <= ST_DRAIN;
                            end else begin
                                band_cnt <= band_cnt + 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once the slot is empty or empties this cycle.
                    if (!patch_valid || patch_ready) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
